// File: rtl/arm_pkg.sv
// Shared constants for the 5-stage ARM core pipeline.
package arm_pkg;

    localparam int unsigned ARM_ADDR_W  = 32;
    localparam int unsigned ARM_INSTR_W = 32;
    localparam int unsigned PC_STEP     = 4;
    localparam int unsigned PERF_W      = 32;

    // MOV r0,r0: the architectural no-op used to fill pipeline bubbles
    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

endpackage

// File: rtl/arm_fetch_stage_if.sv
// Instruction-memory port between the fetch stage and instruction memory.
interface arm_fetch_stage_if
    import arm_pkg::*;
#(
    parameter int unsigned ADDR_W  = ARM_ADDR_W,
    parameter int unsigned INSTR_W = ARM_INSTR_W
);

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/arm_if_id_reg.sv
// IF/ID pipeline register with hold (freeze) and flush (bubble insert).
// Flush takes priority over hold; reset loads a bubble.
module arm_if_id_reg
    import arm_pkg::*;
#(
    parameter int unsigned ADDR_W  = ARM_ADDR_W,
    parameter int unsigned INSTR_W = ARM_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid
);

    // Bubble on reset/flush, keep on hold, otherwise capture the fetch
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if_id_pc    <= '0;
            if_id_instr <= INSTR_W'(NOP_INSTR);
            if_id_valid <= 1'b0;
        end else if (!hold) begin
            if_id_pc    <= pc_in;
            if_id_instr <= instr_in;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/arm_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC mux and IF/ID register.
// Optional macro ARM_FETCH_PERF_CNT_EN adds saturating freeze/bubble counters.
module arm_fetch_stage
    import arm_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ARM_ADDR_W,
    parameter int unsigned       INSTR_W  = ARM_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    arm_fetch_stage_if.master  imem,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
`ifdef ARM_FETCH_PERF_CNT_EN
    output logic [PERF_W-1:0]  freeze_cycles,
    output logic [PERF_W-1:0]  bubble_cycles,
`endif
    output logic               if_id_valid
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_target;
    logic              flush;
    logic              hold;
    logic              unused_branch_lsbs;

    // Targets are word aligned; the low branch bits are deliberately dropped
    assign branch_target      = {branch_addr[ADDR_W-1:2], 2'b00};
    assign unused_branch_lsbs = ^branch_addr[1:0];
    assign pc_plus4           = pc + ADDR_W'(PC_STEP);

    // A taken branch flushes even under freeze; a memory stall only when not frozen
    assign flush = branch_taken || (!freeze && !imem.imem_ready);
    assign hold  = freeze;

    assign imem.imem_addr = pc;

    // PC update: reset > branch > freeze/stall hold > sequential advance
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= branch_target;
        end else if (!freeze && imem.imem_ready) begin
            pc <= pc_plus4;
        end
    end

    arm_if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .flush       (flush),
        .pc_in       (pc_plus4),
        .instr_in    (imem.imem_rdata),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid)
    );

`ifdef ARM_FETCH_PERF_CNT_EN
    // Saturating counts of frozen cycles and bubble-inserting cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_cycles <= '0;
            bubble_cycles <= '0;
        end else begin
            if (freeze && !branch_taken && (freeze_cycles != '1)) begin
                freeze_cycles <= freeze_cycles + PERF_W'(1);
            end
            if (flush && (bubble_cycles != '1)) begin
                bubble_cycles <= bubble_cycles + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Directed self-checking bench for arm_fetch_stage (two instances: RESET_PC 0 and 0xFFFFFFFC).
module tb_arm_fetch_stage;
    import arm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] if_id_pc,   if_id_pc_b;
    logic [31:0] if_id_instr, if_id_instr_b;
    logic        if_id_valid, if_id_valid_b;
`ifdef ARM_FETCH_PERF_CNT_EN
    logic [31:0] freeze_cycles, bubble_cycles;
    logic [31:0] freeze_cycles_b, bubble_cycles_b;
`endif

    int checks = 0;
    int errors = 0;

    arm_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) imem_a ();
    arm_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) imem_b ();

    arm_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem_a.master),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
`ifdef ARM_FETCH_PERF_CNT_EN
        .freeze_cycles(freeze_cycles),
        .bubble_cycles(bubble_cycles),
`endif
        .if_id_valid  (if_id_valid)
    );

    arm_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .freeze       (1'b0),
        .branch_taken (1'b0),
        .branch_addr  (32'h0),
        .imem         (imem_b.master),
        .if_id_pc     (if_id_pc_b),
        .if_id_instr  (if_id_instr_b),
`ifdef ARM_FETCH_PERF_CNT_EN
        .freeze_cycles(freeze_cycles_b),
        .bubble_cycles(bubble_cycles_b),
`endif
        .if_id_valid  (if_id_valid_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc,
                              input logic [31:0] ins, input logic v);
        check({tag, ".pc"},    if_id_pc,    pc);
        check({tag, ".instr"}, if_id_instr, ins);
        check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        imem_a.imem_ready = 1'b1; imem_a.imem_rdata = 32'h0;
        imem_b.imem_ready = 1'b1; imem_b.imem_rdata = 32'hABCD_0000;

        // reset state
        step();
        check("rst.addr", imem_a.imem_addr, 32'h0);
        check_ifid("rst", 32'h0, 32'hE1A0_0000, 1'b0);
        check("rst.addr_wrap", imem_b.imem_addr, 32'hFFFF_FFFC);
`ifdef ARM_FETCH_PERF_CNT_EN
        check("rst.frz_cnt", freeze_cycles, 32'd0);
        check("rst.bub_cnt", bubble_cycles, 32'd0);
`endif

        // sequential fetch
        rst = 1'b0; imem_a.imem_rdata = 32'h11;
        step();
        check("seq1.addr", imem_a.imem_addr, 32'h4);
        check_ifid("seq1", 32'h4, 32'h11, 1'b1);
        // wrap instance: fetch at 0xFFFFFFFC wraps pc+4 to 0
        check("wrap.addr", imem_b.imem_addr, 32'h0);
        check("wrap.ifid_pc", if_id_pc_b, 32'h0);
        check("wrap.instr", if_id_instr_b, 32'hABCD_0000);
        check("wrap.valid", 32'(if_id_valid_b), 32'd1);

        imem_a.imem_rdata = 32'h22;
        step();
        check("seq2.addr", imem_a.imem_addr, 32'h8);
        check_ifid("seq2", 32'h8, 32'h22, 1'b1);

        // freeze two cycles at pc=8, rdata ignored
        freeze = 1'b1; imem_a.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            check("frz.addr", imem_a.imem_addr, 32'h8);
            check_ifid("frz", 32'h8, 32'h22, 1'b1);
        end

        // release: fetch resumes at 8
        freeze = 1'b0; imem_a.imem_rdata = 32'h33;
        step();
        check("rel.addr", imem_a.imem_addr, 32'hC);
        check_ifid("rel", 32'hC, 32'h33, 1'b1);

        imem_a.imem_rdata = 32'h44;
        step();
        check("seq4.addr", imem_a.imem_addr, 32'h10);
        check_ifid("seq4", 32'h10, 32'h44, 1'b1);

        // branch overrides freeze, target aligned down
        branch_taken = 1'b1; branch_addr = 32'h103; freeze = 1'b1;
        imem_a.imem_rdata = 32'h99;
        step();
        check("br.addr", imem_a.imem_addr, 32'h100);
        check_ifid("br", 32'h0, 32'hE1A0_0000, 1'b0);
`ifdef ARM_FETCH_PERF_CNT_EN
        check("br.frz_cnt", freeze_cycles, 32'd2);
        check("br.bub_cnt", bubble_cycles, 32'd1);
`endif

        // redirect to 0x20 for the stall test (another bubble)
        freeze = 1'b0; branch_addr = 32'h20;
        step();
        check("br20.addr", imem_a.imem_addr, 32'h20);
        branch_taken = 1'b0;

        // memory not ready three cycles
        imem_a.imem_ready = 1'b0; imem_a.imem_rdata = 32'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.addr", imem_a.imem_addr, 32'h20);
            check_ifid("stall", 32'h0, 32'hE1A0_0000, 1'b0);
        end
`ifdef ARM_FETCH_PERF_CNT_EN
        check("stall.frz_cnt", freeze_cycles, 32'd2);
        check("stall.bub_cnt", bubble_cycles, 32'd5);
`endif

        imem_a.imem_ready = 1'b1; imem_a.imem_rdata = 32'h66;
        step();
        check("rdy.addr", imem_a.imem_addr, 32'h24);
        check_ifid("rdy", 32'h24, 32'h66, 1'b1);

        // reset mid-freeze wins
        freeze = 1'b1; rst = 1'b1;
        step();
        check("rstfrz.addr", imem_a.imem_addr, 32'h0);
        check_ifid("rstfrz", 32'h0, 32'hE1A0_0000, 1'b0);
`ifdef ARM_FETCH_PERF_CNT_EN
        check("rstfrz.frz_cnt", freeze_cycles, 32'd0);
        check("rstfrz.bub_cnt", bubble_cycles, 32'd0);
`endif

        freeze = 1'b0; rst = 1'b0; imem_a.imem_rdata = 32'h77;
        step();
        check("post.addr", imem_a.imem_addr, 32'h4);
        check_ifid("post", 32'h4, 32'h77, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
